// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_arb_pkg                                               |
// | Purpose  : Shared constants and types for the register-file write        |
// |            arbiter: default widths, write-source codes and the           |
// |            round-robin pointer state encoding.                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package regfile_arb_pkg;

  // Default geometry: 8 registers of 16 bits.
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  // Encoding of rf_src, telling which requester produced the current write.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // Round-robin pointer: names the source that wins when both slots are full.
  typedef enum logic [0:0] {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } arb_ptr_e;

endpackage : regfile_arb_pkg
`default_nettype wire

// File: rtl/regfile_wb_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_wb_slot                                               |
// | Purpose  : One-entry writeback holding slot with a valid/ready input     |
// |            handshake. Requests targeting R0 are accepted and discarded.  |
// |            The slot empties when the arbiter grants it, and can be       |
// |            refilled in that same cycle.                                  |
// | Ports    : clock, reset_n        - clock, async active-low reset         |
// |            in_valid/in_ready     - request handshake                     |
// |            in_rd/in_data         - destination register and data         |
// |            grant                 - arbiter takes the slot this cycle     |
// |            slot_valid/rd/data    - current slot contents                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module regfile_wb_slot
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              slot_valid,
  output logic [ADDR_W-1:0] slot_rd,
  output logic [DATA_W-1:0] slot_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;
  logic              w_accept;
  logic              w_store;

  // Space exists when empty, or when the current entry leaves this cycle.
  assign in_ready = !r_valid || grant;
  assign w_accept = in_valid && in_ready;
  // R0 is hardwired: the handshake completes but nothing is kept.
  assign w_store  = w_accept && (in_rd != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else begin
      if (w_store) begin
        r_valid <= 1'b1;
        r_rd    <= in_rd;
        r_data  <= in_data;
      end else if (grant) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign slot_valid = r_valid;
  assign slot_rd    = r_rd;
  assign slot_data  = r_data;

endmodule : regfile_wb_slot
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_write_arbiter                                         |
// | Purpose  : Shares the single register-file write port between the ALU    |
// |            and memory-load writeback paths. Each path has a one-entry    |
// |            slot; a round-robin arbiter drains the slots into registered  |
// |            rf_we/rf_rw/rf_busw/rf_src outputs. busy_mask reports every   |
// |            register with a write pending in a slot or on the port.       |
// | Ports    : clock, reset_n             - clock, async active-low reset    |
// |            alu_valid/ready/rd/data    - ALU writeback request            |
// |            mem_valid/ready/rd/data    - load writeback request           |
// |            rf_we/rf_rw/rf_busw/rf_src - register-file write port         |
// |            busy_mask                  - pending-write mask (bit0 = 0)    |
// |            byp_ra/rb, byp_hit_a/b,                                       |
// |            byp_data_a/b               - optional same-cycle bypass       |
// | Config   : REGFILE_WR_BYPASS_EN - when defined, adds the bypass ports.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                clock,
  input  logic                reset_n,
  // ALU writeback request
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  // Load writeback request
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  // Register-file write port
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_rw,
  output logic [DATA_W-1:0]   rf_busw,
  output logic                rf_src,
`ifdef REGFILE_WR_BYPASS_EN
  // Same-cycle bypass of the in-flight write
  input  logic [ADDR_W-1:0]   byp_ra,
  input  logic [ADDR_W-1:0]   byp_rb,
  output logic                byp_hit_a,
  output logic                byp_hit_b,
  output logic [DATA_W-1:0]   byp_data_a,
  output logic [DATA_W-1:0]   byp_data_b,
`endif
  // Pending-write mask for RAW hazard detection
  output logic [NUM_REGS-1:0] busy_mask
);

  // ---------------------------------------------------------------------------
  // Holding slots
  // ---------------------------------------------------------------------------
  logic              w_alu_sv;
  logic [ADDR_W-1:0] w_alu_srd;
  logic [DATA_W-1:0] w_alu_sdata;
  logic              w_mem_sv;
  logic [ADDR_W-1:0] w_mem_srd;
  logic [DATA_W-1:0] w_mem_sdata;
  logic              w_grant_alu;
  logic              w_grant_mem;

  regfile_wb_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_alu_slot (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (alu_valid),
    .in_ready   (alu_ready),
    .in_rd      (alu_rd),
    .in_data    (alu_data),
    .grant      (w_grant_alu),
    .slot_valid (w_alu_sv),
    .slot_rd    (w_alu_srd),
    .slot_data  (w_alu_sdata)
  );

  regfile_wb_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_slot (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (mem_valid),
    .in_ready   (mem_ready),
    .in_rd      (mem_rd),
    .in_data    (mem_data),
    .grant      (w_grant_mem),
    .slot_valid (w_mem_sv),
    .slot_rd    (w_mem_srd),
    .slot_data  (w_mem_sdata)
  );

  // ---------------------------------------------------------------------------
  // Round-robin grant. A lone valid slot always wins; on contention the
  // pointer decides. The two grants are mutually exclusive by construction.
  // ---------------------------------------------------------------------------
  arb_ptr_e r_ptr;

  assign w_grant_alu = w_alu_sv && (!w_mem_sv || (r_ptr == PRI_ALU));
  assign w_grant_mem = w_mem_sv && (!w_alu_sv || (r_ptr == PRI_MEM));

  // ---------------------------------------------------------------------------
  // Pointer FSM and registered write port. Address/data/source hold their
  // last value on idle cycles so only rf_we needs to be observed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= PRI_ALU;
      rf_we   <= 1'b0;
      rf_rw   <= '0;
      rf_busw <= '0;
      rf_src  <= SRC_ALU;
    end else begin
      rf_we <= w_grant_alu || w_grant_mem;
      if (w_grant_alu) begin
        r_ptr   <= PRI_MEM;
        rf_rw   <= w_alu_srd;
        rf_busw <= w_alu_sdata;
        rf_src  <= SRC_ALU;
      end else if (w_grant_mem) begin
        r_ptr   <= PRI_ALU;
        rf_rw   <= w_mem_srd;
        rf_busw <= w_mem_sdata;
        rf_src  <= SRC_MEM;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write mask. Slots never hold R0 and the port never writes R0,
  // but bit 0 is forced low so the mask is trivially safe for decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_mask = '0;
    if (w_alu_sv) begin
      busy_mask[w_alu_srd] = 1'b1;
    end
    if (w_mem_sv) begin
      busy_mask[w_mem_srd] = 1'b1;
    end
    if (rf_we) begin
      busy_mask[rf_rw] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

`ifdef REGFILE_WR_BYPASS_EN
  // ---------------------------------------------------------------------------
  // Bypass: expose the value being written this cycle to two read ports,
  // so a reader does not have to wait for the register file to update.
  // ---------------------------------------------------------------------------
  assign byp_hit_a  = rf_we && (rf_rw == byp_ra) && (byp_ra != '0);
  assign byp_hit_b  = rf_we && (rf_rw == byp_rb) && (byp_rb != '0);
  assign byp_data_a = byp_hit_a ? rf_busw : '0;
  assign byp_data_b = byp_hit_b ? rf_busw : '0;
`endif

endmodule : regfile_write_arbiter
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_write_arbiter                                      |
// | Purpose  : Scoreboard bench for regfile_write_arbiter. Directed tests    |
// |            push expected writes into a queue; a negedge monitor pops     |
// |            and compares on every rf_we pulse.                            |
// | Config   : REGFILE_WR_BYPASS_EN - enables the bypass test.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_regfile_write_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          src;
  } wr_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [AW-1:0] alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [AW-1:0] mem_rd = '0;
  logic [DW-1:0] mem_data = '0;
  logic          rf_we;
  logic [AW-1:0] rf_rw;
  logic [DW-1:0] rf_busw;
  logic          rf_src;
  logic [NR-1:0] busy_mask;
`ifdef REGFILE_WR_BYPASS_EN
  logic [AW-1:0] byp_ra = '0;
  logic [AW-1:0] byp_rb = '0;
  logic          byp_hit_a;
  logic          byp_hit_b;
  logic [DW-1:0] byp_data_a;
  logic [DW-1:0] byp_data_b;
`endif

  int  compared = 0;
  int  mismatched = 0;
  wr_t exp_q[$];

  always #5 clock = ~clock;

  regfile_write_arbiter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .rf_we      (rf_we),
    .rf_rw      (rf_rw),
    .rf_busw    (rf_busw),
    .rf_src     (rf_src),
`ifdef REGFILE_WR_BYPASS_EN
    .byp_ra     (byp_ra),
    .byp_rb     (byp_rb),
    .byp_hit_a  (byp_hit_a),
    .byp_hit_b  (byp_hit_b),
    .byp_data_a (byp_data_a),
    .byp_data_b (byp_data_b),
`endif
    .busy_mask  (busy_mask)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input logic [AW-1:0] rd, input logic [DW-1:0] d, input logic s);
    wr_t w;
    w.rd = rd;
    w.data = d;
    w.src = s;
    return w;
  endfunction

  // Scoreboard monitor: every write pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && rf_we) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", rf_rw, rf_busw);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_rd", 32'(rf_rw), 32'(e.rd));
        check("wr_data", 32'(rf_busw), 32'(e.data));
        check("wr_src", 32'(rf_src), 32'(e.src));
      end
      check("busy_on_write", 32'(busy_mask[rf_rw]), 32'd1);
      check("busy_bit0", 32'(busy_mask[0]), 32'd0);
    end
  end

  // Called right after a negedge; returns right after the negedge that
  // follows the accepting posedge.
  task automatic drive_alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    int n = 0;
    alu_valid = 1'b1;
    alu_rd = rd;
    alu_data = d;
    while (!alu_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!alu_ready) begin
      compared++;
      mismatched++;
      $display("FAIL alu_ready_timeout: got ready=0, expected 1 within 20 cycles");
    end
    @(negedge clock);
  endtask

  task automatic drive_mem(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    int n = 0;
    mem_valid = 1'b1;
    mem_rd = rd;
    mem_data = d;
    while (!mem_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!mem_ready) begin
      compared++;
      mismatched++;
      $display("FAIL mem_ready_timeout: got ready=0, expected 1 within 20 cycles");
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic drain_check(input string name);
    repeat (4) @(negedge clock);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_rw", 32'(rf_rw), 32'd0);
    check("rst_rf_busw", 32'(rf_busw), 32'd0);
    check("rst_rf_src", 32'(rf_src), 32'd0);
    check("rst_busy", 32'(busy_mask), 32'd0);
    check("rst_ready", 32'({alu_ready, mem_ready}), 32'b11);
    reset_n = 1'b1;
    @(negedge clock);

    // Test 1: single ALU write, two-edge latency, busy tracking
    exp_q.push_back(mk(3'd3, 16'h1234, 1'b0));
    drive_alu(3'd3, 16'h1234);
    alu_valid = 1'b0;
    check("t1_we_after_E", 32'(rf_we), 32'd0);
    check("t1_busy_slot", 32'(busy_mask), 32'h08);
    @(negedge clock);
    check("t1_we_after_E1", 32'(rf_we), 32'd1);
    check("t1_busy_port", 32'(busy_mask), 32'h08);
    @(negedge clock);
    check("t1_we_pulse_end", 32'(rf_we), 32'd0);
    check("t1_busy_clear", 32'(busy_mask), 32'h00);
    drain_check("t1_drained");

    // Test 2: simultaneous requests, ALU first, pointer returns to ALU
    do_reset();
    exp_q.push_back(mk(3'd1, 16'hAAAA, 1'b0));
    exp_q.push_back(mk(3'd2, 16'h5555, 1'b1));
    fork
      drive_alu(3'd1, 16'hAAAA);
      drive_mem(3'd2, 16'h5555);
    join
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    check("t2_busy_both", 32'(busy_mask), 32'h06);
    repeat (3) @(negedge clock);
    exp_q.push_back(mk(3'd6, 16'h0606, 1'b0));
    exp_q.push_back(mk(3'd7, 16'h0707, 1'b1));
    fork
      drive_alu(3'd6, 16'h0606);
      drive_mem(3'd7, 16'h0707);
    join
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    drain_check("t2_drained");

    // Test 3: sustained contention, one write per cycle, alternating sources
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(3'(i + 1), 16'hA000 + 16'(i), 1'b0));
      exp_q.push_back(mk((i == 3) ? 3'd3 : 3'(i + 5), 16'hB000 + 16'(i), 1'b1));
    end
    fork
      begin
        for (int i = 0; i < 4; i++) drive_alu(3'(i + 1), 16'hA000 + 16'(i));
        alu_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 4; j++) drive_mem((j == 3) ? 3'd3 : 3'(j + 5), 16'hB000 + 16'(j));
        mem_valid = 1'b0;
      end
      begin
        int n = 0;
        while (!rf_we && n < 20) begin
          @(negedge clock);
          n++;
        end
        check("t3_first_write", 32'(rf_we), 32'd1);
        for (int k = 0; k < 7; k++) begin
          @(negedge clock);
          check("t3_back_to_back", 32'(rf_we), 32'd1);
        end
      end
    join
    drain_check("t3_drained");

    // Test 4: write to R0 is accepted and dropped
    do_reset();
    mem_valid = 1'b1;
    mem_rd = 3'd0;
    mem_data = 16'hFFFF;
    check("t4_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clock);
    mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_no_we", 32'(rf_we), 32'd0);
      check("t4_busy_zero", 32'(busy_mask), 32'd0);
      @(negedge clock);
    end
    drain_check("t4_drained");

    // Test 5: async reset with writes in flight
    exp_q.push_back(mk(3'd5, 16'h0001, 1'b0));
    alu_valid = 1'b1; alu_rd = 3'd5; alu_data = 16'h0001;
    mem_valid = 1'b1; mem_rd = 3'd5; mem_data = 16'h4444;
    @(negedge clock);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    check("t5_busy_r5", 32'(busy_mask), 32'h20);
    @(negedge clock);
    check("t5_alu_issued", 32'(rf_we), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_we", 32'(rf_we), 32'd0);
    check("t5_rst_busy", 32'(busy_mask), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    drain_check("t5_no_write_after");

`ifdef REGFILE_WR_BYPASS_EN
    // Test 6: bypass of the in-flight value
    exp_q.push_back(mk(3'd4, 16'hBEEF, 1'b0));
    byp_ra = 3'd4;
    byp_rb = 3'd3;
    drive_alu(3'd4, 16'hBEEF);
    alu_valid = 1'b0;
    check("t6_hit_a_early", 32'(byp_hit_a), 32'd0);
    @(negedge clock);
    check("t6_hit_a", 32'(byp_hit_a), 32'd1);
    check("t6_data_a", 32'(byp_data_a), 32'hBEEF);
    check("t6_hit_b", 32'(byp_hit_b), 32'd0);
    check("t6_data_b", 32'(byp_data_b), 32'd0);
    byp_ra = 3'd0;
    #1;
    check("t6_hit_r0", 32'(byp_hit_a), 32'd0);
    check("t6_data_r0", 32'(byp_data_a), 32'd0);
    drain_check("t6_drained");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_regfile_write_arbiter
`default_nettype wire
